// File: rtl/cocotb_array_pkg.sv
// Shared types and helpers for the array serializer slice.
package cocotb_array_pkg;

  typedef enum logic {
    SER_IDLE,
    SER_SEND
  } ser_state_t;

  // An index for a single-entry dimension still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cocotb_array_serializer_if.sv
// Tile-in / element-out handshake bundle for cocotb_array_serializer.
interface cocotb_array_serializer_if #(
  parameter int W    = 8,
  parameter int ROWS = 3,
  parameter int COLS = 3
);
  import cocotb_array_pkg::*;

  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);

  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_tile [ROWS][COLS];
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [RW-1:0] m_row;
  logic [CW-1:0] m_col;
  logic          m_last;

  modport master (
    output s_valid, s_tile, m_ready,
    input  s_ready, m_valid, m_data, m_row, m_col, m_last
  );

  modport slave (
    input  s_valid, s_tile, m_ready,
    output s_ready, m_valid, m_data, m_row, m_col, m_last
  );

endinterface

// File: rtl/cocotb_array_ser_idx.sv
// Row-major row/column counter; clear wins over advance.
module cocotb_array_ser_idx
  import cocotb_array_pkg::*;
#(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  localparam int RW  = idx_w(ROWS),
  localparam int CW  = idx_w(COLS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          at_last_o
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          row_end, col_end;

  assign row_end = (row_q == ROW_MAX);
  assign col_end = (col_q == COL_MAX);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o     = row_q;
  assign col_o     = col_q;
  assign at_last_o = row_end && col_end;

endmodule

// File: rtl/cocotb_array_serializer.sv
// Captures a ROWS x COLS tile and streams it row-major, one element per beat.
// Optional 16-bit completed-tile counter under `COCOTB_ARRAY_SER_COUNT_EN.
module cocotb_array_serializer
  import cocotb_array_pkg::*;
#(
  parameter int W    = 8,
  parameter int ROWS = 3,
  parameter int COLS = 3
) (
  input  logic clk,
  input  logic rst_n,
  cocotb_array_serializer_if.slave bus
`ifdef COCOTB_ARRAY_SER_COUNT_EN
  ,
  output logic [15:0] tile_count
`endif
);

  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);

  ser_state_t    state_q, state_d;
  logic [W-1:0]  tile_q [ROWS][COLS];
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          at_last;
  logic          m_valid, s_ready, accept, beat;

  always_comb begin
    state_d = state_q;
    m_valid = 1'b0;
    s_ready = 1'b0;
    case (state_q)
      SER_IDLE: s_ready = rst_n;
      SER_SEND: begin
        m_valid = 1'b1;
        // Refill on the edge that retires the final beat: zero-bubble tiles.
        s_ready = rst_n && bus.m_ready && at_last;
      end
      default: state_d = SER_IDLE;
    endcase
    accept = bus.s_valid && s_ready;
    beat   = m_valid && bus.m_ready;
    if (accept)
      state_d = SER_SEND;
    else if (beat && at_last)
      state_d = SER_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SER_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the tile store is reset because idle outputs must read as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          tile_q[r][c] <= '0;
    end else if (accept) begin
      tile_q <= bus.s_tile;
    end
  end

  cocotb_array_ser_idx #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (accept),
    .advance_i (beat),
    .row_o     (row),
    .col_o     (col),
    .at_last_o (at_last)
  );

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_data  = tile_q[row][col];
  assign bus.m_row   = row;
  assign bus.m_col   = col;
  assign bus.m_last  = m_valid && at_last;

`ifdef COCOTB_ARRAY_SER_COUNT_EN
  logic [15:0] tile_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tile_count_q <= '0;
    else if (beat && at_last) tile_count_q <= tile_count_q + 16'd1;
  end

  assign tile_count = tile_count_q;
`endif

endmodule

// File: tb/tb_cocotb_array_serializer.sv
// Directed + randomized bench for cocotb_array_serializer with a beat-queue reference model.
module tb_cocotb_array_serializer;
  import cocotb_array_pkg::*;

  localparam int W    = 8;
  localparam int ROWS = 3;
  localparam int COLS = 3;

  typedef struct {
    logic [W-1:0] data;
    int           row;
    int           col;
    bit           last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cocotb_array_serializer_if #(.W(W), .ROWS(ROWS), .COLS(COLS)) bus ();

`ifdef COCOTB_ARRAY_SER_COUNT_EN
  logic [15:0] tile_count;
`endif

  cocotb_array_serializer #(.W(W), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef COCOTB_ARRAY_SER_COUNT_EN
    ,
    .tile_count (tile_count)
`endif
  );

  int           checks = 0;
  int           errors = 0;
  beat_t        exp_q[$];
  logic [W-1:0] drive_tile [ROWS][COLS];
  int           tiles_done = 0;
  bit           last_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: a captured tile becomes ROWS*COLS beats in row-major order; only the last index is last.
  function automatic void push_tile(input logic [W-1:0] t [ROWS][COLS]);
    for (int k = 0; k < ROWS * COLS; k++) begin
      beat_t b;
      b.row  = k / COLS;
      b.col  = k % COLS;
      b.data = t[b.row][b.col];
      b.last = (k == ROWS * COLS - 1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic fill_pattern(input int base);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        drive_tile[r][c] = W'(base + r * COLS + c);
  endtask

  task automatic fill_const(input logic [W-1:0] v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        drive_tile[r][c] = v;
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        drive_tile[r][c] = W'($urandom);
  endtask

  // One clock cycle: drive, compare against the model, then advance the model on the edge.
  task automatic cycle(input bit sv, input bit mr);
    bit    exp_ready, acc, beat;
    beat_t b;
    bus.s_valid = sv;
    bus.m_ready = mr;
    bus.s_tile  = drive_tile;
    #1;
    exp_ready = (exp_q.size() == 0) || (mr && exp_q.size() == 1);
    check("s_ready", 32'(bus.s_ready), 32'(exp_ready));
    check("m_valid", 32'(bus.m_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      b = exp_q[0];
      check("m_data", 32'(bus.m_data), 32'(b.data));
      check("m_row",  32'(bus.m_row),  32'(b.row));
      check("m_col",  32'(bus.m_col),  32'(b.col));
      check("m_last", 32'(bus.m_last), 32'(b.last));
    end else begin
      check("m_last_idle", 32'(bus.m_last), 32'd0);
    end
`ifdef COCOTB_ARRAY_SER_COUNT_EN
    check("tile_count", 32'(tile_count), 32'(tiles_done % 65536));
`endif
    acc  = sv && exp_ready;
    beat = mr && (exp_q.size() > 0);
    @(posedge clk);
    if (beat) begin
      b = exp_q.pop_front();
      if (b.last) tiles_done++;
    end
    if (acc) push_tile(drive_tile);
    last_acc = acc;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    check({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    check({tag, "_m_data"},  32'(bus.m_data),  32'd0);
    check({tag, "_m_row"},   32'(bus.m_row),   32'd0);
    check({tag, "_m_col"},   32'(bus.m_col),   32'd0);
    check({tag, "_m_last"},  32'(bus.m_last),  32'd0);
  endtask

  initial begin
    int  n;
    bit  offering;

    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    fill_const('0);
    bus.s_tile = drive_tile;

    // Reset held: all outputs at reset values.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Tile 0..8 streamed with m_ready high: 9 consecutive beats, then idle.
    fill_pattern(0);
    cycle(1'b1, 1'b1);
    check("t1_accept", 32'(last_acc), 32'd1);
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin cycle(1'b0, 1'b1); n++; end
    check("t1_cycles", n, 9);
    cycle(1'b0, 1'b1);

    // Same tile, m_ready alternating 1,0: held beats, 17 cycles total.
    cycle(1'b1, 1'b1);
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin cycle(1'b0, (n % 2) == 0); n++; end
    check("t2_cycles", n, 17);

    // Back-to-back tiles with s_valid held: second captured on the first tile's last beat.
    fill_pattern(0);
    cycle(1'b1, 1'b1);
    fill_pattern(16);
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 50) begin cycle(1'b1, 1'b1); n++; end
    check("t3_second_accept_cycle", n, 9);
    fill_const(8'hFF);
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin cycle(1'b0, 1'b1); n++; end
    check("t3_second_tile_cycles", n, 9);

    // Input overwritten during SEND while downstream stalls randomly.
    fill_pattern(0);
    cycle(1'b1, 1'b1);
    fill_const(8'hFF);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin cycle(1'b0, 1'($urandom)); n++; end
    check("t4_drained", exp_q.size(), 0);

    // Reset mid-tile after four beats: immediate reset outputs, no stale beats afterwards.
    fill_pattern(0);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    tiles_done = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) cycle(1'b0, 1'b1);

    // Randomized traffic: offers held until accepted, random backpressure.
    offering = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!offering && ($urandom_range(0, 2) == 0)) begin
        fill_random();
        offering = 1'b1;
      end
      cycle(offering, 1'($urandom_range(0, 3) != 0));
      if (last_acc) offering = 1'b0;
    end
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin cycle(1'b0, 1'b1); n++; end
    check("rand_drained", exp_q.size(), 0);
    cycle(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
